text_console_writer: RTL
========================

// Module: text_console_writer
// PURPOSE
//   Writer side of the on-screen text path: accepts a stream of ASCII bytes and
//   stores them in a COLSxROWS character RAM, managing a cursor with CR/LF/BS/FF.
//   The renderer reads the RAM through a pixel-addressed read port (x,y) and gets
//   back a 7-bit ROM char code, which it combines with row/bit addressing from x,y.
//   Sits between a byte source (UART rx / game FSM) and the text overlay renderer.
// PARAMETERS
//   COLS  80  character columns (8-px cells; 80*8 = 640)
//   ROWS  30  character rows (16-px cells; 30*16 = 480)
// PORTS
//   clk         in   1   system clock; all logic rising-edge
//   reset       in   1   synchronous, active-high reset
//   wr_valid    in   1   wr_data valid
//   wr_data     in   8   ASCII byte to write/interpret
//   wr_ready    out  1   block can accept a byte this cycle
//   x           in   10  current pixel column from sync generator
//   y           in   10  current pixel row from sync generator
//   char_code   out  7   char at cell (x[9:3], y[8:4]); 1-cycle latency
//   cursor_col  out  7   current cursor column, 0..COLS-1
//   cursor_row  out  5   current cursor row, 0..ROWS-1
//   busy        out  1   high while a screen clear is in progress
// BEHAVIOUR
// - Reset: cursor_col=0, cursor_row=0, char_code=0, wr_ready=0, busy=1; FSM -> CLEAR.
// - FSM states: CLEAR, IDLE. No other states.
// - CLEAR: clr_addr counts 0..COLS*ROWS-1, writes 7'h00 (blank) one cell/cycle;
//   after last cell (COLS*ROWS cycles) -> IDLE, busy=0, wr_ready=1 next cycle.
//   Cursor held at (0,0) throughout. wr_ready=0 so no byte is accepted.
// - IDLE: wr_ready=1. Byte accepted iff wr_valid && wr_ready; processed same
//   cycle (RAM write + cursor update at that edge); back-to-back every cycle OK.
// - Byte decode (on accept):
//   0x20..0x7E : write wr_data[6:0] at (col,row); advance cursor.
//   0x0D (CR)  : col=0, row unchanged, no write.
//   0x0A (LF)  : row advances (wrap), col unchanged, no write.
//   0x08 (BS)  : if col>0: col=col-1 and write 7'h00 at new (col-1,row);
//                if col==0: no-op (no row back-step).
//   0x0C (FF)  : cursor=(0,0), -> CLEAR, wr_ready=0 from next cycle.
//   any other  : accepted and discarded; no write, cursor unchanged.
// - Advance: col==COLS-1 -> col=0 and row advances; else col+1.
//   Row advance: row==ROWS-1 -> row=0 (wrap to top, no scroll); else row+1.
// - RAM index = row*COLS + col (13 bits, max COLS*ROWS-1 = 2399).
// - Read port: cell = (x[9:3], y[8:4]); char_code registered one clk later.
//   x[9:3]>=COLS or y[9:4]>=ROWS -> char_code=7'h00 (out-of-range blank).
//   Read-first on same-cell collision: returns previous contents that cycle.
//   Read port runs in all states, including CLEAR and during reset de-assert.
// - Reset asserted mid-CLEAR or mid-stream: restarts CLEAR from address 0.
// - wr_data ignored whenever wr_ready=0; source must hold wr_valid until accepted.
// TESTING
// - Reset, hold 2400+2 cycles -> busy falls after exactly 2400 IDLE-less cycles;
//   wr_ready=1; every cell (sweep x,y) reads 7'h00.
// - Send "HI" (0x48,0x49) back-to-back -> cells (0,0)=7'h48,(1,0)=7'h49; cursor=(2,0).
// - Cursor at (79,29), send 0x41 -> cell (79,29)=7'h41, cursor wraps to (0,0).
// - Send "AB",0x08,0x08,0x08 -> cell (1,0)=0, (0,0)=0, cursor (0,0) after 3rd BS.
// - Send "X",0x0D,0x0A,"Y" -> (0,0)=7'h58, (0,1)=7'h59, cursor=(1,1); 0x07 ignored.
// - Mid-stream 0x0C then wr_valid held high -> wr_ready=0 for 2400 cycles, no byte
//   lost (held byte accepted first IDLE cycle at (0,0)); x=640 -> char_code=0.

Source files
------------

// File: rtl/text_console_writer_if.sv
// Byte-stream write channel into the text console.
//
// Handshake: the source drives wr_valid/wr_data and must hold both stable
// until it sees wr_ready high at a rising clock edge. A byte transfers on
// every edge where wr_valid && wr_ready. wr_data is ignored while wr_ready
// is low. wr_ready does not depend on wr_valid.
interface text_console_writer_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/text_console_writer.sv
// Writer side of the text overlay. ASCII bytes arrive on the write channel
// and are stored in a COLS x ROWS character RAM. The cursor is managed with
// CR/LF/BS/FF. The renderer reads the RAM through a pixel-addressed port
// with one cycle of latency.
module text_console_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  text_console_writer_if.slave wr,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  output logic [6:0]           char_code,
  output logic [6:0]           cursor_col,
  output logic [4:0]           cursor_row,
  output logic                 busy,
  output logic [0:0]           dbg_state_o
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = 13;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  // Linear cell index for a (column, row) pair.
  function automatic logic [AW-1:0] cell_index(input logic [6:0] c,
                                               input logic [4:0] r);
    return AW'(r) * AW'(COLS) + AW'(c);
  endfunction

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [6:0]    col_q, col_d;
  logic [4:0]    row_q, row_d;

  logic [6:0]    mem [0:CELLS-1];

  logic          we;
  logic [AW-1:0] waddr;
  logic [6:0]    wdata;

  logic          accept;
  logic [4:0]    row_inc;
  logic          printable;

  logic          rd_in_range;
  logic [AW-1:0] rd_addr;
  logic [6:0]    rd_data_q;
  logic          rd_valid_q;

  // The pixel bits that select a position within a cell belong to the renderer.
  logic          unused_pix_bits;
  assign unused_pix_bits = ^{x[2:0], y[3:0]};

  // Bytes are accepted only in IDLE. Reset blocks acceptance in the same cycle,
  // so a byte that arrives during reset is never lost.
  assign wr.wr_ready = (state_q == ST_IDLE) && !reset;
  assign accept      = wr.wr_valid && wr.wr_ready;

  assign row_inc   = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;
  assign printable = (wr.wr_data >= 8'h20) && (wr.wr_data <= 8'h7E);

  // Next-state logic: the clear sweep, then byte decode with cursor movement.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    col_d      = col_q;
    row_d      = row_q;
    we         = 1'b0;
    waddr      = cell_index(col_q, row_q);
    wdata      = 7'h00;

    if (state_q == ST_CLEAR) begin
      // Blank one cell per cycle. The cursor stays parked at the origin.
      we    = 1'b1;
      waddr = clr_addr_q;
      col_d = 7'd0;
      row_d = 5'd0;
      if (clr_addr_q == AW'(CELLS - 1)) begin
        state_d    = ST_IDLE;
        clr_addr_d = '0;
      end else begin
        clr_addr_d = clr_addr_q + AW'(1);
      end
    end else if (accept) begin
      if (printable) begin
        we    = 1'b1;
        wdata = wr.wr_data[6:0];
        if (col_q == 7'(COLS - 1)) begin
          col_d = 7'd0;
          row_d = row_inc;
        end else begin
          col_d = col_q + 7'd1;
        end
      end else begin
        case (wr.wr_data)
          CH_CR: col_d = 7'd0;
          CH_LF: row_d = row_inc;
          CH_BS: begin
            // Backspace erases the cell it lands on. It does not step back across rows.
            if (col_q != 7'd0) begin
              col_d = col_q - 7'd1;
              we    = 1'b1;
              waddr = cell_index(col_q - 7'd1, row_q);
              wdata = 7'h00;
            end
          end
          CH_FF: begin
            col_d      = 7'd0;
            row_d      = 5'd0;
            clr_addr_d = '0;
            state_d    = ST_CLEAR;
          end
          default: ;
        endcase
      end
    end
  end

  // State, clear counter and cursor registers. Reset restarts the clear from cell 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      col_q      <= 7'd0;
      row_q      <= 5'd0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      col_q      <= col_d;
      row_q      <= row_d;
    end
  end

  // Read address from the pixel position. Cells off the right or bottom edge read as blank.
  assign rd_in_range = (x[9:3] < 7'(COLS)) && (y[9:4] < 6'(ROWS));
  assign rd_addr     = rd_in_range ? cell_index(x[9:3], y[8:4]) : '0;

  // Character RAM: one write port and one read-first read port.
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem[waddr] <= wdata;
    end
    rd_data_q <= mem[rd_addr];
  end

  // Qualifier for the registered read. Forces blank output during reset and off-screen.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_in_range;
    end
  end

  assign char_code   = rd_valid_q ? rd_data_q : 7'h00;
  assign cursor_col  = col_q;
  assign cursor_row  = row_q;
  assign busy        = (state_q == ST_CLEAR);
  assign dbg_state_o = state_q;

endmodule
